// File: rtl/apb_master_arbiter_if.sv
// Bundles the requester-side handshake and the APB bus signals of apb_master_arbiter.
// Latency: none; this is wiring only.
// Backpressure: requesters hold req_valid until req_ready; the slave stretches with pready.
// Ports: req_valid/req_write/req_addr/req_wdata in, req_ready/rsp_valid/rsp_rdata/rsp_err out,
//        paddr/prwd/pwdata/psel/penable out, prdata/pready/pslverr in (arbiter view = master).
interface apb_master_arbiter_if #(
  parameter int NUM_REQ      = 2,
  parameter int PADDR_WIDTH  = 32,
  parameter int PWDATA_WIDTH = 32,
  parameter int PRDATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ-1:0]              req_write;
  logic [NUM_REQ*PADDR_WIDTH-1:0]  req_addr;
  logic [NUM_REQ*PWDATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]              req_ready;
  logic [NUM_REQ-1:0]              rsp_valid;
  logic [PRDATA_WIDTH-1:0]         rsp_rdata;
  logic                            rsp_err;
  logic [PADDR_WIDTH-1:0]          paddr;
  logic                            prwd;
  logic [PWDATA_WIDTH-1:0]         pwdata;
  logic                            psel;
  logic                            penable;
  logic [PRDATA_WIDTH-1:0]         prdata;
  logic                            pready;
  logic                            pslverr;

  // Arbiter side.
  modport master (
    input  req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, paddr, prwd, pwdata, psel, penable
  );

  // Environment side: requesters plus the APB slave.
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, paddr, prwd, pwdata, psel, penable
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter that sequences NUM_REQ local requesters onto one APB slave port.
// Latency: request seen in IDLE at T -> SETUP T+1, ACCESS T+2, response T+3 with no wait states.
// Backpressure: pready wait states stall ACCESS (bounded by TIMEOUT); losers hold req_valid.
// Ports: pclock, preset (async, active high); bus = apb_master_arbiter_if.master carrying the
//        requester handshake (req_*/rsp_*) and the APB signals (paddr..penable, prdata..pslverr).
module apb_master_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int PADDR_WIDTH  = 32,
  parameter int PWDATA_WIDTH = 32,
  parameter int PRDATA_WIDTH = 32,
  parameter int TIMEOUT      = 16
) (
  input  logic                 pclock,
  input  logic                 preset,
  apb_master_arbiter_if.master bus
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  // Last wait cycle allowed; pready still low in this cycle aborts the transfer.
  localparam logic [TW-1:0] TLAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);
  localparam logic [IW:0] NREQ_W = (IW+1)'(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t        state;
  logic [IW-1:0] rr_ptr;   // first requester searched at the next decision
  logic [IW-1:0] grant;    // owner of the transfer in flight
  logic [TW-1:0] timer;

  logic          found;
  logic [IW-1:0] win;
  logic [IW-1:0] win_next;
  logic [IW:0]   idx;
  logic          rest;

  // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr} + (IW+1)'(k);
      if (idx >= NREQ_W) idx = idx - NREQ_W;
      if (!found && bus.req_valid[idx[IW-1:0]]) begin
        found = 1'b1;
        win   = idx[IW-1:0];
      end
    end
  end

  assign win_next = (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;

  // The IDLE cycle that carries rsp_valid is a rest cycle: no decision is taken in it,
  // so every transfer occupies at least four cycles and a requester that sees its
  // response has a full cycle to present its next request before arbitration.
  assign rest = |bus.rsp_valid;

  always_ff @(posedge pclock or posedge preset) begin
    if (preset) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      grant         <= '0;
      timer         <= '0;
      bus.psel      <= 1'b0;
      bus.penable   <= 1'b0;
      bus.prwd      <= 1'b0;
      bus.paddr     <= '0;
      bus.pwdata    <= '0;
      bus.req_ready <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      bus.req_ready <= '0;
      bus.rsp_valid <= '0;
      case (state)
        IDLE: begin
          bus.psel    <= 1'b0;
          bus.penable <= 1'b0;
          if (found && !rest) begin
            state         <= SETUP;
            bus.psel      <= 1'b1;
            bus.req_ready <= ONE << win;
            bus.paddr     <= bus.req_addr[win*PADDR_WIDTH +: PADDR_WIDTH];
            bus.prwd      <= bus.req_write[win];
            bus.pwdata    <= bus.req_wdata[win*PWDATA_WIDTH +: PWDATA_WIDTH];
            grant         <= win;
            rr_ptr        <= win_next;
          end
        end
        SETUP: begin
          state       <= ACCESS;
          bus.penable <= 1'b1;
          timer       <= '0;
        end
        ACCESS: begin
          if (bus.pready) begin
            state         <= IDLE;
            bus.psel      <= 1'b0;
            bus.penable   <= 1'b0;
            bus.rsp_valid <= ONE << grant;
            bus.rsp_err   <= bus.pslverr;
            bus.rsp_rdata <= bus.prwd ? '0 : bus.prdata;
          end else if ((TIMEOUT > 0) && (timer == TLAST)) begin
            state         <= IDLE;
            bus.psel      <= 1'b0;
            bus.penable   <= 1'b0;
            bus.rsp_valid <= ONE << grant;
            bus.rsp_err   <= 1'b1;
            bus.rsp_rdata <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          bus.psel    <= 1'b0;
          bus.penable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: requester drivers, an APB slave model, a round-robin
// reference model and a response scoreboard checked by an independent monitor.
module tb_apb_master_arbiter;
  localparam int NR = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RW = 32;
  localparam int TO = 4;

  logic pclock = 1'b0;
  logic preset = 1'b0;
  always #5 pclock = ~pclock;

  apb_master_arbiter_if #(.NUM_REQ(NR), .PADDR_WIDTH(AW), .PWDATA_WIDTH(DW),
                          .PRDATA_WIDTH(RW)) bus ();

  apb_master_arbiter #(.NUM_REQ(NR), .PADDR_WIDTH(AW), .PWDATA_WIDTH(DW),
                       .PRDATA_WIDTH(RW), .TIMEOUT(TO)) dut (
    .pclock (pclock),
    .preset (preset),
    .bus    (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rsp_count = 0;
  always @(posedge pclock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Requester payloads as driven by the bench, plus the snapshot seen at the previous negedge.
  logic [AW-1:0] m_addr [NR];
  logic          m_write[NR];
  logic [DW-1:0] m_wdata[NR];
  bit            hold   [NR];
  logic [NR-1:0] pv;
  logic [AW-1:0] pa [NR];
  logic          pw [NR];
  logic [DW-1:0] pd [NR];

  // Reference arbitration state and the transfer currently on the bus.
  int            ptr = 0;
  int            waitc[NR];
  int            cur_id = 0;
  logic [AW-1:0] cur_addr = '0;
  logic          cur_write = 1'b0;
  logic [DW-1:0] cur_wdata = '0;

  typedef struct { int w; logic err; logic [RW-1:0] rdata; } slv_t;
  typedef struct { int id; logic err; logic [RW-1:0] rdata; int at; } exp_t;
  slv_t force_q[$];
  exp_t exp_q[$];
  logic          last_err = 1'b0;
  logic [RW-1:0] last_rdata = '0;

  task automatic add_force(input int w, input logic err, input logic [RW-1:0] rdata);
    slv_t s;
    s.w = w; s.err = err; s.rdata = rdata;
    force_q.push_back(s);
  endtask

  // APB slave model: picks the wait count / error / data per transfer and pushes the
  // expected response (requester, flags, cycle) when the first ACCESS cycle appears.
  initial begin
    bit   in_acc;
    int   cnt;
    slv_t s;
    exp_t e;
    in_acc = 0; cnt = 0;
    s.w = 0; s.err = 0; s.rdata = '0;
    bus.pready = 1'b0; bus.pslverr = 1'b0; bus.prdata = '0;
    forever begin
      @(posedge pclock); #1;
      if (preset) begin
        in_acc = 0; bus.pready = 1'b0; bus.pslverr = 1'b0;
        force_q.delete();
      end else if (bus.psel && bus.penable) begin
        if (!in_acc) begin
          in_acc = 1; cnt = 0;
          if (force_q.size() > 0) s = force_q.pop_front();
          else begin
            s.w     = ($urandom_range(0, 9) == 0) ? 6 : int'($urandom_range(0, 3));
            s.err   = ($urandom_range(0, 7) == 0);
            s.rdata = $urandom;
          end
          e.id = cur_id;
          if (s.w >= TO) begin
            e.err = 1'b1; e.rdata = '0; e.at = cyc + TO;
          end else begin
            e.err = s.err; e.rdata = cur_write ? '0 : s.rdata; e.at = cyc + s.w + 1;
          end
          exp_q.push_back(e);
        end else cnt++;
        bus.pready  = (cnt == s.w);
        bus.pslverr = s.err && (cnt == s.w);
        bus.prdata  = s.rdata;
      end else begin
        in_acc = 0; bus.pready = 1'b0; bus.pslverr = 1'b0; bus.prdata = $urandom;
      end
    end
  end

  // Monitor: grant order, bus stability, responses and output hold, all sampled at negedge.
  initial begin
    exp_t e;
    int pred;
    logic [NR-1:0] oh;
    forever begin
      @(negedge pclock);
      if (preset) begin
        chk("rst_no_rsp", bus.rsp_valid, '0);
        ptr = 0; exp_q.delete(); last_err = 1'b0; last_rdata = '0;
        for (int i = 0; i < NR; i++) waitc[i] = 0;
      end else begin
        if (bus.req_ready != '0) begin
          pred = -1;
          for (int k = 0; k < NR; k++)
            if (pred < 0 && pv[(ptr + k) % NR]) pred = (ptr + k) % NR;
          if (pred < 0) chk("grant_without_request", bus.req_ready, '0);
          else begin
            oh = '0; oh[pred] = 1'b1;
            chk("grant", bus.req_ready, oh);
            chk("setup_phase", {bus.psel, bus.penable}, 2'b10);
            for (int i = 0; i < NR; i++) begin
              if (i == pred || !pv[i]) waitc[i] = 0;
              else begin
                waitc[i]++;
                chk("starvation_bound", waitc[i] <= NR - 1, 1);
              end
            end
            ptr = (pred + 1) % NR;
            cur_id = pred; cur_addr = pa[pred]; cur_write = pw[pred]; cur_wdata = pd[pred];
          end
        end else if (bus.psel && !bus.penable) begin
          chk("setup_without_grant", bus.req_ready != '0, 1);
        end
        if (bus.psel && bus.penable) begin
          chk("paddr_stable", bus.paddr, cur_addr);
          chk("prwd_stable", bus.prwd, cur_write);
          chk("pwdata_stable", bus.pwdata, cur_wdata);
        end
        if (bus.rsp_valid != '0) begin
          if (exp_q.size() == 0) chk("unexpected_rsp", bus.rsp_valid, '0);
          else begin
            e = exp_q.pop_front();
            oh = '0; oh[e.id] = 1'b1;
            rsp_count++;
            chk("rsp_valid", bus.rsp_valid, oh);
            chk("rsp_err", bus.rsp_err, e.err);
            chk("rsp_rdata", bus.rsp_rdata, e.rdata);
            chk("rsp_cycle", cyc, e.at);
            chk("rsp_bus_idle", {bus.psel, bus.penable}, 2'b00);
            last_err = e.err; last_rdata = e.rdata;
          end
        end else begin
          chk("rdata_hold", bus.rsp_rdata, last_rdata);
          chk("err_hold", bus.rsp_err, last_err);
        end
      end
      pv = bus.req_valid;
      for (int i = 0; i < NR; i++) begin
        pa[i] = m_addr[i]; pw[i] = m_write[i]; pd[i] = m_wdata[i];
      end
    end
  end

  // Advance to just after the next rising edge; accepted requesters drop req_valid.
  task automatic step();
    @(posedge pclock); #1;
    for (int i = 0; i < NR; i++)
      if (bus.req_ready[i] && !hold[i]) bus.req_valid[i] = 1'b0;
  endtask

  task automatic issue(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_addr[i] = a; m_write[i] = w; m_wdata[i] = d;
    bus.req_addr[i*AW +: AW]  = a;
    bus.req_write[i]          = w;
    bus.req_wdata[i*DW +: DW] = d;
    bus.req_valid[i]          = 1'b1;
  endtask

  task automatic run_until_rsp(input int budget, output logic [NR-1:0] v, output logic e,
                               output logic [RW-1:0] d, output int at, output int n_sel,
                               output int n_en);
    v = '0; e = 1'b0; d = '0; at = -1; n_sel = 0; n_en = 0;
    for (int c = 0; c < budget; c++) begin
      step();
      @(negedge pclock);
      if (bus.psel) n_sel++;
      if (bus.penable) n_en++;
      if (bus.rsp_valid != '0) begin
        v = bus.rsp_valid; e = bus.rsp_err; d = bus.rsp_rdata; at = cyc;
        break;
      end
    end
    chk("rsp_seen", |v, 1'b1);
  endtask

  task automatic drain(input int budget);
    int c;
    for (c = 0; c < budget; c++) begin
      step();
      @(negedge pclock);
      if (bus.req_valid == '0 && exp_q.size() == 0 && !bus.psel && !bus.penable) break;
    end
    chk("drain_idle", c < budget, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NR-1:0] v;
    logic          e;
    logic [RW-1:0] d;
    int at, t0, n_sel, n_en, issued, base, c;
    logic [NR-1:0] rec[$];

    bus.req_valid = '0; bus.req_write = '0; bus.req_addr = '0; bus.req_wdata = '0;
    for (int i = 0; i < NR; i++) begin
      m_addr[i] = '0; m_write[i] = 1'b0; m_wdata[i] = '0; hold[i] = 0; waitc[i] = 0;
    end
    #1 preset = 1'b1;
    repeat (2) @(negedge pclock);
    chk("rst_psel", bus.psel, 0);
    chk("rst_penable", bus.penable, 0);
    chk("rst_prwd", bus.prwd, 0);
    chk("rst_paddr", bus.paddr, 0);
    chk("rst_pwdata", bus.pwdata, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    @(posedge pclock); #1 preset = 1'b0;

    // Single zero-wait read.
    add_force(0, 1'b0, 32'hDEAD_BEEF);
    step(); issue(0, 1'b0, 32'h0000_0010, '0); t0 = cyc;
    run_until_rsp(20, v, e, d, at, n_sel, n_en);
    chk("read_latency", at - t0, 3);
    chk("read_psel_cycles", n_sel, 2);
    chk("read_penable_cycles", n_en, 1);
    chk("read_rsp_valid", v, 3'b001);
    chk("read_rdata", d, 32'hDEAD_BEEF);
    chk("read_err", e, 0);
    repeat (2) step();

    // Write with three wait states.
    add_force(3, 1'b0, 32'h5555_AAAA);
    step(); issue(1, 1'b1, 32'h0000_0020, 32'h1234_5678); t0 = cyc;
    run_until_rsp(20, v, e, d, at, n_sel, n_en);
    chk("write_latency", at - t0, 6);
    chk("write_access_cycles", n_en, 4);
    chk("write_rsp_valid", v, 3'b010);
    chk("write_rdata", d, 0);
    chk("write_err", e, 0);
    repeat (2) step();

    // Slave error on a read keeps the read data.
    add_force(1, 1'b1, 32'hA5A5_0001);
    step(); issue(2, 1'b0, 32'h0000_0030, '0);
    run_until_rsp(20, v, e, d, at, n_sel, n_en);
    chk("slverr_rsp_valid", v, 3'b100);
    chk("slverr_err", e, 1);
    chk("slverr_rdata", d, 32'hA5A5_0001);
    repeat (2) step();

    // Timeout followed by a queued normal transfer.
    add_force(9, 1'b0, 32'hFFFF_0000);
    add_force(0, 1'b0, 32'h0000_1111);
    step(); issue(0, 1'b0, 32'h40, '0); issue(1, 1'b0, 32'h44, '0);
    run_until_rsp(30, v, e, d, at, n_sel, n_en);
    chk("timeout_err", e, 1);
    chk("timeout_rdata", d, 0);
    chk("timeout_access_cycles", n_en, TO);
    run_until_rsp(30, v, e, d, at, n_sel, n_en);
    chk("after_timeout_err", e, 0);
    chk("after_timeout_rdata", d, 32'h0000_1111);
    drain(100);

    // Round-robin with two requesters held from reset.
    preset = 1'b1;
    hold[0] = 1; hold[1] = 1;
    issue(0, 1'b0, 32'h100, '0); issue(1, 1'b1, 32'h104, 32'hCAFE_0001);
    step(); step(); preset = 1'b0;
    for (c = 0; c < 100 && rec.size() < 4; c++) begin
      step(); @(negedge pclock);
      if (bus.req_ready != '0) rec.push_back(bus.req_ready);
    end
    chk("rr_grants", rec.size(), 4);
    for (int k = 0; k < 4; k++) chk("rr_order", rec[k], (k % 2 == 0) ? 3'b001 : 3'b010);
    hold[0] = 0; hold[1] = 0;
    drain(100);

    // Reset during an ACCESS wait state.
    add_force(9, 1'b0, 32'h0);
    step(); issue(0, 1'b0, 32'h50, '0);
    n_en = 0;
    for (c = 0; c < 20 && n_en < 2; c++) begin
      step(); @(negedge pclock);
      if (bus.penable) n_en++;
    end
    chk("mid_access_reached", n_en, 2);
    #2 preset = 1'b1;
    #1;
    chk("async_rst_psel", bus.psel, 0);
    chk("async_rst_penable", bus.penable, 0);
    chk("async_rst_req_ready", bus.req_ready, 0);
    chk("async_rst_rsp_valid", bus.rsp_valid, 0);
    issue(1, 1'b0, 32'h60, '0); issue(0, 1'b0, 32'h64, '0);
    step(); step(); preset = 1'b0;
    v = '0;
    for (c = 0; c < 20 && v == '0; c++) begin
      step(); @(negedge pclock);
      v = bus.req_ready;
    end
    chk("rst_first_grant", v, 3'b001);
    drain(100);

    // Randomized traffic on all requesters.
    issued = 0; base = rsp_count;
    for (c = 0; c < 3000 && issued < 150; c++) begin
      step();
      for (int i = 0; i < NR; i++)
        if (!bus.req_valid[i] && issued < 150 && $urandom_range(0, 2) == 0) begin
          issue(i, 1'(($urandom_range(0, 1))), $urandom, $urandom);
          issued++;
        end
    end
    drain(600);
    chk("random_rsp_count", rsp_count - base, issued);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
